// File: rtl/pf_ram_ctl_if.sv
// CPU access bus for the playfield RAM controller: request/ack handshake.
// Latency: n/a (signal bundle only).
// Backpressure: the requester holds req/we/addr/wdata stable until ack.
//
// Ports (master = CPU side, slave = controller side):
//   cpu_req   request, held until cpu_ack
//   cpu_we    1 = write, 0 = read
//   cpu_addr  byte address, bank = [9:8], offset = [7:0]
//   cpu_wdata write data
//   cpu_rdata read data, valid in the cpu_ack cycle
//   cpu_ack   one-cycle access-complete pulse
interface pf_ram_ctl_if;
   logic       cpu_req;
   logic       cpu_we;
   logic [9:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_ack;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack
   );
endinterface

// File: rtl/pf_ram_ctl.sv
// Playfield RAM controller: port A arbitrates CPU access vs. zero-fill clear, port B fetches one tile row into a line buffer.
// Latency: CPU ack 2 cycles after req sampled; clear 1024 writes + done; fetch 32 reads + done; lb_code 1 cycle.
// Backpressure: CPU is stalled (ack withheld) while a clear runs; starts arriving while busy are dropped.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   cpu                   CPU request/ack bus (slave side)
//   clear_start/busy/done zero-fill command and status
//   fetch_start/row/busy/done  line fetch command and status
//   lb_col / lb_code      line buffer column read (registered)
//   ram_*_a               RAM port A (shared CPU / clear), active-low strobes
//   ram_*_b               RAM port B (line fetch), all four banks read in parallel
module pf_ram_ctl (
   input  logic        clk,
   input  logic        reset_n,
   pf_ram_ctl_if.slave cpu,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   input  logic        fetch_start,
   input  logic [4:0]  fetch_row,
   output logic        fetch_busy,
   output logic        fetch_done,
   input  logic [4:0]  lb_col,
   output logic [7:0]  lb_code,
   output logic [7:0]  ram_addr_a,
   output logic [7:0]  ram_din_a,
   input  logic [7:0]  ram_dout_a,
   output logic [3:0]  ram_ce_a,
   output logic [3:0]  ram_we_a,
   output logic [7:0]  ram_addr_b,
   input  logic [31:0] ram_dout_b,
   output logic [3:0]  ram_ce_b
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      CPU_ACK = 2'd2,
      CLR     = 2'd3
   } state_t;

   // ---------------- port A state ----------------
   state_t      state_q, state_d;
   logic [7:0]  addr_a_q, addr_a_d;
   logic [7:0]  din_a_q, din_a_d;
   logic [3:0]  ce_a_q, ce_a_d;
   logic [3:0]  we_a_q, we_a_d;
   logic        acc_we_q, acc_we_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic [9:0]  clr_k_q, clr_k_d;
   logic        clear_pend_q, clear_pend_d;
   logic        clear_busy_q, clear_busy_d;
   logic        clear_done_q, clear_done_d;
   logic [9:0]  clr_k_nxt;
   logic [3:0]  cpu_bank_sel;
   logic [3:0]  clr_bank_sel;

   // ---------------- port B / line buffer state ----------------
   logic [4:0]  row_q, row_d;
   logic [4:0]  col_q, col_d;
   logic [7:0]  addr_b_q, addr_b_d;
   logic [3:0]  ce_b_q, ce_b_d;
   logic        fetch_busy_q, fetch_busy_d;
   logic        fetch_done_q, fetch_done_d;
   logic [7:0]  lb_code_q, lb_code_d;
   logic        lb_we;
   logic [4:0]  lb_waddr;
   logic [7:0]  lb_wdata;
   logic [7:0]  lb_mem [32];

   assign clr_k_nxt    = clr_k_q + 10'd1;
   // One-hot active-low bank decodes
   assign cpu_bank_sel = ~(4'b0001 << cpu.cpu_addr[9:8]);
   assign clr_bank_sel = ~(4'b0001 << clr_k_nxt[9:8]);

   always_comb begin
      state_d      = state_q;
      addr_a_d     = addr_a_q;
      din_a_d      = din_a_q;
      ce_a_d       = ce_a_q;
      we_a_d       = we_a_q;
      acc_we_d     = acc_we_q;
      rdata_d      = rdata_q;
      ack_d        = 1'b0;
      clr_k_d      = clr_k_q;
      clear_busy_d = clear_busy_q;
      clear_done_d = 1'b0;
      // A start during a running clear is dropped; otherwise it waits for IDLE.
      clear_pend_d = clear_pend_q | (clear_start & ~clear_busy_q);

      case (state_q)
         IDLE: begin
            // CPU wins over a pending clear so it never waits behind a fresh request.
            if (cpu.cpu_req) begin
               state_d  = CPU_ACC;
               addr_a_d = cpu.cpu_addr[7:0];
               ce_a_d   = cpu_bank_sel;
               acc_we_d = cpu.cpu_we;
               if (cpu.cpu_we) begin
                  we_a_d  = cpu_bank_sel;
                  din_a_d = cpu.cpu_wdata;
               end
            end else if (clear_pend_q) begin
               state_d      = CLR;
               clr_k_d      = 10'd0;
               addr_a_d     = 8'h00;
               din_a_d      = 8'h00;
               ce_a_d       = 4'b1110;
               we_a_d       = 4'b1110;
               clear_busy_d = 1'b1;
            end
         end
         CPU_ACC: begin
            state_d = CPU_ACK;
            if (!acc_we_q) begin
               rdata_d = ram_dout_a;
            end
            ce_a_d = 4'hF;
            we_a_d = 4'hF;
            ack_d  = 1'b1;
         end
         CPU_ACK: begin
            // Turnaround cycle: the held request is not re-sampled until IDLE.
            state_d = IDLE;
         end
         CLR: begin
            if (clr_k_q == 10'd1023) begin
               state_d      = IDLE;
               ce_a_d       = 4'hF;
               we_a_d       = 4'hF;
               clear_busy_d = 1'b0;
               clear_done_d = 1'b1;
               clear_pend_d = 1'b0;
            end else begin
               clr_k_d  = clr_k_nxt;
               addr_a_d = clr_k_nxt[7:0];
               ce_a_d   = clr_bank_sel;
               we_a_d   = clr_bank_sel;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      row_d        = row_q;
      col_d        = col_q;
      addr_b_d     = addr_b_q;
      ce_b_d       = ce_b_q;
      fetch_busy_d = fetch_busy_q;
      fetch_done_d = 1'b0;
      lb_we        = 1'b0;
      lb_waddr     = col_q;
      // Row bits [4:3] pick the bank, i.e. the byte lane of the 32-bit port.
      lb_wdata     = ram_dout_b[{row_q[4:3], 3'b000} +: 8];

      if (fetch_busy_q) begin
         lb_we = 1'b1;
         if (col_q == 5'd31) begin
            fetch_busy_d = 1'b0;
            fetch_done_d = 1'b1;
            ce_b_d       = 4'hF;
         end else begin
            col_d    = col_q + 5'd1;
            addr_b_d = {row_q[2:0], col_q + 5'd1};
         end
      end else if (fetch_start) begin
         row_d        = fetch_row;
         col_d        = 5'd0;
         addr_b_d     = {fetch_row[2:0], 5'd0};
         ce_b_d       = 4'h0;
         fetch_busy_d = 1'b1;
      end

      lb_code_d = lb_mem[lb_col];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         addr_a_q     <= 8'h00;
         din_a_q      <= 8'h00;
         ce_a_q       <= 4'hF;
         we_a_q       <= 4'hF;
         acc_we_q     <= 1'b0;
         rdata_q      <= 8'h00;
         ack_q        <= 1'b0;
         clr_k_q      <= 10'd0;
         clear_pend_q <= 1'b0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
         row_q        <= 5'd0;
         col_q        <= 5'd0;
         addr_b_q     <= 8'h00;
         ce_b_q       <= 4'hF;
         fetch_busy_q <= 1'b0;
         fetch_done_q <= 1'b0;
         lb_code_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         addr_a_q     <= addr_a_d;
         din_a_q      <= din_a_d;
         ce_a_q       <= ce_a_d;
         we_a_q       <= we_a_d;
         acc_we_q     <= acc_we_d;
         rdata_q      <= rdata_d;
         ack_q        <= ack_d;
         clr_k_q      <= clr_k_d;
         clear_pend_q <= clear_pend_d;
         clear_busy_q <= clear_busy_d;
         clear_done_q <= clear_done_d;
         row_q        <= row_d;
         col_q        <= col_d;
         addr_b_q     <= addr_b_d;
         ce_b_q       <= ce_b_d;
         fetch_busy_q <= fetch_busy_d;
         fetch_done_q <= fetch_done_d;
         lb_code_q    <= lb_code_d;
      end
   end

   // Line buffer storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb_mem[lb_waddr] <= lb_wdata;
      end
   end

   assign cpu.cpu_rdata = rdata_q;
   assign cpu.cpu_ack   = ack_q;
   assign clear_busy    = clear_busy_q;
   assign clear_done    = clear_done_q;
   assign fetch_busy    = fetch_busy_q;
   assign fetch_done    = fetch_done_q;
   assign lb_code       = lb_code_q;
   assign ram_addr_a    = addr_a_q;
   assign ram_din_a     = din_a_q;
   assign ram_ce_a      = ce_a_q;
   assign ram_we_a      = we_a_q;
   assign ram_addr_b    = addr_b_q;
   assign ram_ce_b      = ce_b_q;

endmodule

// File: doc/pf_ram_ctl.md
# pf_ram_ctl

Controller for the dual-port playfield RAM (4 banks × 256 bytes, active-low bank selects). Port A is shared between the CPU bus and a hardware clear engine. The clear engine zero-fills all 1024 bytes on command. Port B is driven by a line-fetch sequencer that copies one 32-tile playfield row into a local line buffer, which the video pipeline then reads by column.

## Interface
Parameters: none.
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  10  playfield byte address: bank = [9:8], offset = [7:0]
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid in the cpu_ack cycle
- cpu_ack  out  1  one-cycle access-complete pulse
- clear_start  in  1  one-cycle pulse: zero entire RAM
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- fetch_start  in  1  one-cycle pulse: fetch the row given by fetch_row
- fetch_row  in  5  tile row 0..31, sampled with fetch_start
- fetch_busy  out  1  row fetch in progress
- fetch_done  out  1  one-cycle pulse after column 31 is captured
- lb_col  in  5  line-buffer read column
- lb_code  out  8  line-buffer byte at lb_col, registered
- ram_addr_a  out  8  port A offset
- ram_din_a  out  8  port A write data
- ram_dout_a  in  8  port A read data (combinational from RAM)
- ram_ce_a  out  4  port A bank select, one-hot active-low
- ram_we_a  out  4  port A write enable, one-hot active-low
- ram_addr_b  out  8  port B offset
- ram_dout_b  in  32  port B data; bank n on bits [8n+7:8n]
- ram_ce_b  out  4  port B enable, active-low; all-low while fetching

## Operation
- Port A FSM states: IDLE, CPU_ACC, CPU_ACK, CLR.
- IDLE → CPU_ACC on cpu_req.
  - Register ram_addr_a = cpu_addr[7:0].
  - Drive ram_ce_a[cpu_addr[9:8]] = 0.
  - On a write, also drive ram_we_a[bank] = 0 and ram_din_a = cpu_wdata.
- CPU_ACC → CPU_ACK. On a read, latch ram_dout_a into cpu_rdata. Deassert ce/we to 4'hF. Pulse cpu_ack.
- CPU_ACK → IDLE. cpu_req is ignored in CPU_ACK. If cpu_req is still high in IDLE, it is treated as a new access.
- Clear arbitration:
  - clear_start arriving in any state sets clear_pend.
  - IDLE with clear_pend → CLR. When cpu_req and clear_pend are both present in IDLE, the CPU access is served first.
- CLR uses a 10-bit counter k = 0..1023, one write per cycle.
  - Per cycle: ram_addr_a = k[7:0], ram_we_a[k[9:8]] = 0, ram_ce_a[k[9:8]] = 0, ram_din_a = 0.
  - After k = 1023: pulse clear_done, clear clear_pend, return to IDLE.
  - clear_busy is high from CLR entry through the last write.
  - clear_start while clear_busy is ignored.
- Line fetch runs independently of port A.
  - fetch_start while not busy: latch the row, set fetch_busy, column counter c = 0..31.
  - Per cycle: byte address = {row, c}. Drive ram_addr_b = {row[2:0], c} and ram_ce_b = 4'h0.
  - Capture lane row[4:3] of ram_dout_b into line buffer entry c.
  - After c = 31: pulse fetch_done, ram_ce_b = 4'hF, clear fetch_busy.
  - fetch_start while fetch_busy is ignored.
- Line buffer: 32 × 8, written only by the fetcher. lb_code <= buf[lb_col] every cycle.
- A port A write and a port B fetch of the same byte in the same cycle: the fetch captures the new data (RAM is write-through). No other coherence is provided.

## Timing
- Reset values: ram_ce_a = ram_we_a = ram_ce_b = 4'hF; every other output 0; clear_pend 0; FSM in IDLE. Line buffer contents are not reset.
- Reset asserted mid-clear or mid-fetch aborts it immediately. Strobes go high asynchronously. No done pulse. Partial RAM contents are left as written.
- CPU access: cpu_req sampled in IDLE at edge N. Strobes are active during cycle N+1. cpu_ack and cpu_rdata are valid in cycle N+2.
- CPU wait during a clear is at most 1024 + 2 cycles.
- Clear: CLR entered at edge N. Writes occur in cycles N+1..N+1024. clear_done is high in cycle N+1025.
- Fetch: fetch_start at edge N. Columns are read in cycles N+1..N+32. fetch_done is high in cycle N+33.
- lb_code latency is 1 cycle after lb_col.

## Test plan
- CPU writes 0x5A to 0x2C7, then reads it back.
  - Write: ram_we_a = 4'b1011, ram_addr_a = 0xC7, cpu_ack 2 cycles after req.
  - Read: cpu_rdata = 0x5A with ack.
- clear_start with RAM pre-filled with 0xFF.
  - 1024 consecutive writes; clear_done 1025 cycles after CLR entry.
  - Subsequent reads of 0x000, 0x1FF and 0x3FF return 0.
- cpu_req asserted 10 cycles into a clear → ack arrives exactly 2 cycles after clear_done. Write data lands after the zero-fill.
- cpu_req and clear_start in the same IDLE cycle → CPU ack at N+2. CLR starts afterwards; clear_done still pulses once.
- Pattern byte = addr[7:0] ^ {6'b0, addr[9:8]} written everywhere, then fetch_row = 13.
  - ram_addr_b steps 0xA0..0xBF; ram_ce_b = 0 for 32 cycles.
  - lb_code for lb_col = 5 is 0xA5 ^ 0x01 = 0xA4.
- reset_n pulsed low at clear k = 300 → strobes high immediately, no clear_done. Addresses 0x000..0x12B read 0, 0x12C reads the prior value.
